data_mem_banked: RTL

DATA_MEM_BANKED -- requirements
Module: data_mem_banked

---
 rtl/data_mem_banked.sv | 107 ++++++++++
 1 files changed

// File: rtl/data_mem_banked.sv
// Byte-lane word memory that self-clears after reset, then serves one read or
// masked write per clock with a registered one-cycle response.
module data_mem_banked #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 128,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req,
   input  logic                we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W/8-1:0] be,
   input  logic [DATA_W-1:0]   wdata,
   output logic                ready,
   output logic                done,
   output logic [DATA_W-1:0]   rdata,
   output logic                err
);
   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t            state;
   state_t            state_next;
   logic [IDX_W-1:0]  clear_idx;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              accept;
   logic              in_range;
   logic              last_clear;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] cur_word;
   logic [DATA_W-1:0] merged;
   logic              done_r;
   logic              err_r;

   // Every address bit above the index must be zero for an in-range access.
   assign idx        = addr[IDX_W-1:0];
   assign in_range   = (addr >> IDX_W) == '0;
   assign last_clear = clear_idx == IDX_W'(DEPTH - 1);
   assign accept     = req && (state == RUN) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CLEAR;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (state == CLEAR && last_clear) begin
         state_next = RUN;
      end
   end

   // Reset masks a response already registered so an interrupted request never completes.
   always_comb begin
      ready = (state == RUN);
      done  = done_r && !reset;
      err   = err_r && !reset;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         clear_idx <= '0;
      end else if (state == CLEAR && !last_clear) begin
         clear_idx <= clear_idx + 1'b1;
      end
   end

   always_comb begin
      cur_word = mem[idx];
      merged   = cur_word;
      for (int i = 0; i < NB; i++) begin
         if (we && be[i]) begin
            merged[8*i +: 8] = wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR) begin
            mem[clear_idx] <= '0;
         end else if (accept && in_range && we) begin
            mem[idx] <= merged;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         done_r <= 1'b0;
         err_r  <= 1'b0;
         rdata  <= '0;
      end else begin
         done_r <= accept;
         err_r  <= accept && !in_range;
         if (accept) begin
            rdata <= in_range ? merged : '0;
         end
      end
   end
endmodule
